color_cmd_ctrl: RTL

Command controller between the UART byte receiver and the colour/PWM datapath. It decodes the nibble-pair command bytes arriving over the serial link and assembles them into the four 8-bit channel registers: red, green, blue and intensity. A channel register changes only when a complete, consistent low/high nibble pair has arrived, so downstream logic never sees a half-updated value. The block also flags malformed or orphaned bytes.

---
 rtl/color_cmd_ctrl_pkg.sv | 22 ++
 rtl/color_cmd_ctrl_timeout_cnt.sv | 30 +++
 rtl/color_cmd_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/color_cmd_ctrl_pkg.sv
// Shared constants for the colour command controller: channel indices,
// command byte field positions and FSM state encoding.
package color_cmd_ctrl_pkg;

    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_GREEN = 2'd1;
    localparam logic [1:0] CH_BLUE  = 2'd2;
    localparam logic [1:0] CH_INT   = 2'd3;

    localparam int HI_BIT  = 7;
    localparam int RSV_BIT = 6;
    localparam int CH_MSB  = 5;
    localparam int CH_LSB  = 4;
    localparam int NIB_MSB = 3;
    localparam int NIB_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/color_cmd_ctrl_timeout_cnt.sv
// Saturating inter-byte timeout counter. Clear restarts the count; expire is
// asserted on the enabled cycle where the count sits at TIMEOUT_CYCLES-1.
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TO_W           = 18
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt;
    logic            w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_expire  = i_en && w_at_last;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/color_cmd_ctrl.sv
// Nibble-pair command decoder driving the red/green/blue/intensity registers.
// Define CMD_TIMEOUT_EN to build the low/high inter-byte timeout.
module color_cmd_ctrl
    import color_cmd_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TO_W           = 18
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_red,
    output logic [7:0] o_green,
    output logic [7:0] o_blue,
    output logic [7:0] o_intensity,
    output logic       o_update,
    output logic [1:0] o_update_ch,
    output logic       o_pending,
    output logic       o_cmd_err
);

    state_t          r_state;
    logic [3:0][7:0] r_chan;
    logic [1:0]      r_pend_ch;
    logic [3:0]      r_pend_nib;
    logic            r_update;
    logic [1:0]      r_update_ch;
    logic            r_pending;
    logic            r_cmd_err;

    logic       w_hi;
    logic       w_rsv;
    logic [1:0] w_ch;
    logic [3:0] w_nib;
    logic       w_expire;

    assign w_hi  = i_rx_data[HI_BIT];
    assign w_rsv = i_rx_data[RSV_BIT];
    assign w_ch  = i_rx_data[CH_MSB:CH_LSB];
    assign w_nib = i_rx_data[NIB_MSB:NIB_LSB];

`ifdef CMD_TIMEOUT_EN
    logic w_to_clr;
    logic w_to_en;

    // Every accepted low nibble restarts the wait for its partner.
    assign w_to_clr = i_rx_valid && !w_rsv && !w_hi;
    assign w_to_en  = (r_state == ST_PEND) && !i_rx_valid;

    cmd_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    (w_to_clr),
        .i_en     (w_to_en),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_chan      <= '0;
            r_pend_ch   <= '0;
            r_pend_nib  <= '0;
            r_update    <= 1'b0;
            r_update_ch <= '0;
            r_pending   <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_update  <= 1'b0;
            r_cmd_err <= 1'b0;
            if (i_rx_valid) begin
                if (w_rsv) begin
                    r_cmd_err <= 1'b1;
                end else if (!w_hi) begin
                    // Low nibble: in PEND it orphans the held one.
                    r_cmd_err  <= (r_state == ST_PEND);
                    r_pend_ch  <= w_ch;
                    r_pend_nib <= w_nib;
                    r_state    <= ST_PEND;
                    r_pending  <= 1'b1;
                end else if (r_state == ST_IDLE) begin
                    r_cmd_err <= 1'b1;
                end else begin
                    if (w_ch == r_pend_ch) begin
                        r_chan[w_ch] <= {w_nib, r_pend_nib};
                        r_update     <= 1'b1;
                        r_update_ch  <= w_ch;
                    end else begin
                        r_cmd_err <= 1'b1;
                    end
                    r_state    <= ST_IDLE;
                    r_pending  <= 1'b0;
                    r_pend_ch  <= '0;
                    r_pend_nib <= '0;
                end
            end else if (w_expire) begin
                r_cmd_err  <= 1'b1;
                r_state    <= ST_IDLE;
                r_pending  <= 1'b0;
                r_pend_ch  <= '0;
                r_pend_nib <= '0;
            end
        end
    end

    assign o_red       = r_chan[CH_RED];
    assign o_green     = r_chan[CH_GREEN];
    assign o_blue      = r_chan[CH_BLUE];
    assign o_intensity = r_chan[CH_INT];
    assign o_update    = r_update;
    assign o_update_ch = r_update_ch;
    assign o_pending   = r_pending;
    assign o_cmd_err   = r_cmd_err;

endmodule
